// File: rtl/id_inst_queue.sv
// -----------------------------------------------------------------------------
// id_inst_queue
//
// First-word-fall-through instruction queue sitting between the IF and ID
// stages of the 5-stage MIPS pipeline. It replaces the single IF/ID latch
// and its one-entry hold of SRAM read data during a stall. The queue holds
// up to DEPTH {pc, inst} pairs. Both sides use valid/ready handshakes.
//
// A branch flush empties the queue. In keep-oldest mode the flush instead
// retains the oldest surviving entry, which is the delay-slot instruction.
//
// Parameters
//   DEPTH     number of entries (power of two, 2..16)
//   PC_W      PC field width
//   INST_W    instruction field width
//   AFULL_TH  almost_full asserts when count >= AFULL_TH (1..DEPTH)
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   in_valid/in_ready  IF-side handshake; the fetched word is {in_pc, in_inst}
//   out_valid/out_ready ID-side handshake; the head word is {out_pc, out_inst}
//   flush              branch taken / pipeline flush (overrides push)
//   flush_keep_oldest  together with flush, keep the oldest entry
//   count              number of occupied entries
//   almost_full        registered; asserted when count >= AFULL_TH
// -----------------------------------------------------------------------------
module id_inst_queue #(
    parameter int DEPTH    = 4,
    parameter int PC_W     = 32,
    parameter int INST_W   = 32,
    parameter int AFULL_TH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INST_W-1:0]          in_inst,

    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [INST_W-1:0]          out_inst,

    input  logic                       flush,
    input  logic                       flush_keep_oldest,

    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t          mem [DEPTH];

    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    logic            push;
    logic            pop;
    logic [AW-1:0]   rd_ptr_popped;
    logic [CW-1:0]   count_popped;
    logic [AW-1:0]   rd_ptr_next;
    logic [AW-1:0]   wr_ptr_next;
    logic [CW-1:0]   count_next;
    entry_t          head;

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    // in_ready deliberately ignores a same-cycle pop. A full queue never
    // accepts a word, which keeps in_ready free of any path from out_ready.
    assign in_ready  = (count < CW'(DEPTH)) && !rst;
    assign out_valid = (count != '0);

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready;

    // The head is read combinationally, so it stays stable while ID stalls.
    // When the queue is empty the don't-care storage entry is still driven,
    // which keeps the output free of floating values.
    assign head     = mem[rd_ptr];
    assign out_pc   = head.pc;
    assign out_inst = head.inst;

    // -------------------------------------------------------------------------
    // Next-state pointer and occupancy
    // -------------------------------------------------------------------------
    // The consumer side is honoured even during a flush. A word that ID takes
    // on the flush edge counts as consumed, so flush acts on the post-pop view.
    assign rd_ptr_popped = rd_ptr + AW'(pop);
    assign count_popped  = count - CW'(pop);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        rd_ptr_next = rd_ptr_popped;
        wr_ptr_next = wr_ptr + AW'(push);
        count_next  = count_popped + CW'(push);

        if (flush) begin
            if (flush_keep_oldest && (count_popped != '0)) begin
                // Keep only the entry at the post-pop head (the delay slot).
                count_next  = CW'(1);
                wr_ptr_next = rd_ptr_popped + AW'(1);
            end else begin
                count_next  = '0;
                wr_ptr_next = rd_ptr_popped;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge, whatever order the statements
    // are written in.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            rd_ptr      <= rd_ptr_next;
            wr_ptr      <= wr_ptr_next;
            count       <= count_next;
            // Computed from the next-state count, so it lines up with count.
            almost_full <= (count_next >= CW'(AFULL_TH));
        end
    end

    // NOTE: storage is deliberately left without reset. Only entries covered
    // by count are ever observed, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: in_pc, inst: in_inst};
        end
    end

endmodule

// File: doc/id_inst_queue.md
Name: id_inst_queue

Overview:
- Parametrised, first-word-fall-through instruction queue between IF and ID in the 5-stage MIPS pipeline.
- Replaces the single-register IF/ID latch and its one-entry hold of SRAM read data during a stall with a DEPTH-entry buffer of {pc, inst} pairs.
- Uses valid/ready handshakes on both sides.
- Supports branch flush, with an optional keep-oldest mode that preserves the delay-slot instruction.

Parameters:
DEPTH, 4, number of entries; power of two, 2..16
PC_W, 32, PC field width
INST_W, 32, instruction field width
AFULL_TH, DEPTH-1, count at or above which almost_full is asserted; range 1..DEPTH

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  IF presents {in_pc, in_inst}
in_ready  out  1  queue can accept the IF word
in_pc  in  PC_W  PC of the fetched instruction
in_inst  in  INST_W  instruction word, already aligned to in_valid
out_valid  out  1  head entry valid for ID
out_ready  in  1  ID consumes head this cycle (deasserted by ID stall)
out_pc  out  PC_W  head PC
out_inst  out  INST_W  head instruction
flush  in  1  branch taken / pipeline flush
flush_keep_oldest  in  1  with flush, retain the oldest entry (delay slot)
count  out  $clog2(DEPTH+1)  occupied entries
almost_full  out  1  count >= AFULL_TH

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. While rst is high at a posedge:
  - count=0, rd/wr pointers=0, out_valid=0, almost_full=0.
  - Storage contents are don't-care.
  - in_ready is 0 while rst is asserted and 1 on the first cycle after release.
- Push:
  - push = in_valid & in_ready & ~flush.
  - in_ready = (count < DEPTH) & ~rst. It does not depend on a same-cycle pop, so a full queue never accepts a word even while popping.
- Pop:
  - pop = out_valid & out_ready.
  - out_valid = (count != 0).
  - out_pc/out_inst are driven combinationally from the storage entry at rd_ptr, so they hold stable while out_ready=0.
- Latency: a word pushed at edge N appears at out_* with out_valid=1 after edge N. There is no combinational in-to-out bypass.
- Pointers wrap modulo DEPTH. count is updated as +push -pop, so a simultaneous push and pop leaves count unchanged.
- Flush has priority over push and is evaluated at the edge:
  - flush & ~flush_keep_oldest → count=0, wr_ptr=rd_ptr (post-pop rd_ptr). Same-cycle push and pop are still honoured for the consumer only: a popped word counts as consumed.
  - flush & flush_keep_oldest:
    - If count_after_pop >= 1, keep exactly the entry at the post-pop rd_ptr; count=1, wr_ptr=rd_ptr+1.
    - If count_after_pop = 0, count=0.
  - The same-cycle push is always discarded.
- Stall tolerance: with out_ready=0 the head is held indefinitely. Storage is written only on push, never overwritten.
- almost_full is registered. It is derived from the next-state count so it aligns with count.
- No X may propagate on out_* when out_valid=0; drive the storage entry, whose value is don't-care.

Test Plan:
- Fill and drain (DEPTH=4): push pc 0xBFC00000..0xBFC0000C with out_ready=0. Required: count 1..4, in_ready=0 after the 4th push, almost_full=1 from count=3. Then out_ready=1: pcs pop in order, one per cycle, count reaches 0 and out_valid=0.
- Simultaneous push/pop at count=2 for 10 cycles. Required: count stays 2, order preserved, pointers wrap past 3→0 without corruption.
- Push while full with a concurrent pop. Required: in_ready=0, the word is not accepted, count drops to 3 the next cycle.
- Plain flush at count=3 with a concurrent push of pc 0x100. Required: next cycle count=0, out_valid=0, in_ready=1; 0x100 never appears.
- Keep-oldest flush at count=3 (heads A,B,C) with out_ready=1, so A pops. Required: only B remains, count=1, out_pc=B; the next push lands behind B.
- Reset mid-operation at count=2. Required: count=0, out_valid=0 next cycle, in_ready=0 during rst. A subsequent push emerges alone after one cycle.
